// File: rtl/n100_ilm_ecc_dec.sv
// SECDED decoder/corrector for 40-bit ILM/DLM read-return words, with a 2-stage elastic pipeline and error log.
// Define N100_ECC_SCRUB_EN to add the write-back scrub FSM; otherwise the scrub outputs are tied low.
module n100_ilm_ecc_dec #(
  parameter int AW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ecc_en,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [AW-1:0] i_addr,
  input  logic [39:0]   i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [31:0]   o_data,
  output logic          o_sbe,
  output logic          o_dbe,
  output logic          err_vld,
  output logic [AW-1:0] err_addr,
  output logic [6:0]    err_syndrome,
  input  logic          err_clr,
  output logic [CW-1:0] sbe_cnt,
  output logic [CW-1:0] dbe_cnt,
  output logic          scrub_req,
  input  logic          scrub_ack,
  output logic [AW-1:0] scrub_addr,
  output logic [39:0]   scrub_wdata
);

  // Place data bits into codeword positions 1..38; power-of-2 positions stay empty.
  function automatic logic [38:1] spread(input logic [31:0] d);
    logic [38:1] cw;
    logic [4:0]  j;
    cw = '0;
    j  = '0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[j];
        j     = j + 5'd1;
      end
    end
    return cw;
  endfunction

  function automatic logic [31:0] gather(input logic [38:1] cw);
    logic [31:0] d;
    logic [4:0]  j;
    d = '0;
    j = '0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = cw[p];
        j    = j + 5'd1;
      end
    end
    return d;
  endfunction

  function automatic logic [5:0] hamming(input logic [38:1] cw);
    logic [5:0] c;
    c = '0;
    for (int k = 0; k < 6; k++) begin
      for (int p = 1; p <= 38; p++) begin
        if (((p >> k) & 1) != 0) c[k] = c[k] ^ cw[p];
      end
    end
    return c;
  endfunction

  logic          s1_vld, s1_en, s1_adv, s1_load;
  logic [AW-1:0] s1_addr;
  logic [31:0]   s1_data;
  logic [6:0]    s1_syn;
  logic [6:0]    syn_in;
  logic          s2_vld, s2_load, out_hs;
  logic [AW-1:0] s2_addr;
  logic [6:0]    s2_syn;
  logic [31:0]   fix_data;
  logic          fix_sbe, fix_dbe;
  logic [38:1]   flip;
  logic [5:0]    syn_s;
  logic          syn_p;
  logic          new_err, log_dbe;

  assign s2_load = !s2_vld || o_ready;
  assign s1_adv  = s1_vld && s2_load;
  assign s1_load = !s1_vld || s1_adv;
  assign i_ready = s1_load;
  assign o_valid = s2_vld;
  assign out_hs  = s2_vld && o_ready;

  assign syn_in = {^i_data[38:0], i_data[37:32] ^ hamming(spread(i_data[31:0]))};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_en   <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
      s1_syn  <= '0;
    end else if (s1_load) begin
      s1_vld <= i_valid;
      if (i_valid) begin
        s1_en   <= ecc_en;
        s1_addr <= i_addr;
        s1_data <= i_data[31:0];
        s1_syn  <= syn_in;
      end
    end
  end

  // Flipping a check-bit slot (or nothing, s=0) leaves the gathered data untouched.
  always_comb begin
    syn_s    = s1_syn[5:0];
    syn_p    = s1_syn[6];
    fix_data = s1_data;
    fix_sbe  = 1'b0;
    fix_dbe  = 1'b0;
    flip     = '0;
    for (int p = 1; p <= 38; p++) begin
      if (p[5:0] == syn_s) flip[p] = 1'b1;
    end
    if (s1_en) begin
      if (!syn_p) begin
        fix_dbe = (syn_s != 6'd0);
      end else if (syn_s > 6'd38) begin
        fix_dbe = 1'b1;
      end else begin
        fix_sbe  = 1'b1;
        fix_data = gather(spread(s1_data) ^ flip);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_addr <= '0;
      s2_syn  <= '0;
      o_data  <= '0;
      o_sbe   <= 1'b0;
      o_dbe   <= 1'b0;
    end else if (s2_load) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_addr <= s1_addr;
        s2_syn  <= s1_syn;
        o_data  <= fix_data;
        o_sbe   <= fix_sbe;
        o_dbe   <= fix_dbe;
      end
    end
  end

  assign new_err = out_hs && (o_sbe || o_dbe);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_vld      <= 1'b0;
      log_dbe      <= 1'b0;
      err_addr     <= '0;
      err_syndrome <= '0;
      sbe_cnt      <= '0;
      dbe_cnt      <= '0;
    end else if (err_clr) begin
      err_vld      <= new_err;
      log_dbe      <= new_err && o_dbe;
      err_addr     <= new_err ? s2_addr : '0;
      err_syndrome <= new_err ? s2_syn : '0;
      sbe_cnt      <= (out_hs && o_sbe) ? CW'(1) : '0;
      dbe_cnt      <= (out_hs && o_dbe) ? CW'(1) : '0;
    end else begin
      if (new_err && (!err_vld || (o_dbe && !log_dbe))) begin
        err_vld      <= 1'b1;
        log_dbe      <= o_dbe;
        err_addr     <= s2_addr;
        err_syndrome <= s2_syn;
      end
      if (out_hs && o_sbe && !(&sbe_cnt)) sbe_cnt <= sbe_cnt + CW'(1);
      if (out_hs && o_dbe && !(&dbe_cnt)) dbe_cnt <= dbe_cnt + CW'(1);
    end
  end

`ifdef N100_ECC_SCRUB_EN
  // state  | meaning
  // S_IDLE | no scrub pending; next handshaken SBE word is captured
  // S_REQ  | scrub_req held with latched addr/word until scrub_ack
  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} scrub_state_t;

  scrub_state_t state, state_nxt;
  logic         scrub_go;

  function automatic logic [39:0] encode(input logic [31:0] d);
    logic [5:0] h;
    h = hamming(spread(d));
    return {1'b0, ^{h, d}, h, d};
  endfunction

  logic unused_bits;
  assign unused_bits = i_data[39];

  assign scrub_go = (state == S_IDLE) && out_hs && o_sbe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (scrub_go) state_nxt = S_REQ;
      S_REQ:   if (scrub_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    scrub_req = (state == S_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scrub_addr  <= '0;
      scrub_wdata <= '0;
    end else if (scrub_go) begin
      scrub_addr  <= s2_addr;
      scrub_wdata <= encode(o_data);
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{i_data[39], scrub_ack};

  assign scrub_req   = 1'b0;
  assign scrub_addr  = '0;
  assign scrub_wdata = '0;
`endif

endmodule
